// File: rtl/alu_result_buffer.sv
// ============================================================================
// Module: alu_result_buffer
//
// Purpose
//   Output stage that follows the ALU result multiplexer. Each selected ALU
//   result is captured with its opcode tag into a DEPTH-entry FIFO. The head
//   entry is offered to the consumer over a valid/ready handshake, together
//   with a zero flag and a sticky overflow flag. The FIFO decouples the ALU
//   issue rate from consumer back-pressure.
//
// Parameters
//   INPUT_WIDTH   width of the ALU result
//   OPCODE_WIDTH  width of the opcode tag stored with each result
//   DEPTH         number of FIFO entries (power of two, >= 2)
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst         asynchronous, active-high reset
//   clear       synchronous flush of the FIFO and the overflow flag
//   in_valid    in_data/in_opcode hold a result to capture
//   in_data     ALU result
//   in_opcode   opcode that produced in_data
//   in_ready    buffer can accept (count != DEPTH)
//   out_valid   head entry available (count != 0)
//   out_data    head result; 0 when out_valid = 0
//   out_opcode  head opcode tag; 0 when out_valid = 0
//   out_zero    out_valid & (out_data == 0)
//   out_ready   consumer takes the head entry
//   count       current occupancy, 0..DEPTH
//   overflow    sticky: in_valid seen while in_ready = 0
//   out_parity  (ALU_RESULT_PARITY_EN only) ^out_data when out_valid, else 0
//
// Configuration
//   ALU_RESULT_PARITY_EN  when defined, parity is computed at push, stored as
//                         one extra bit per entry and presented on out_parity.
// ============================================================================
module alu_result_buffer #(
   parameter int INPUT_WIDTH  = 8,
   parameter int OPCODE_WIDTH = 2,
   parameter int DEPTH        = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      in_valid,
   input  logic [INPUT_WIDTH-1:0]    in_data,
   input  logic [OPCODE_WIDTH-1:0]   in_opcode,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [INPUT_WIDTH-1:0]    out_data,
   output logic [OPCODE_WIDTH-1:0]   out_opcode,
   output logic                      out_zero,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow
`ifdef ALU_RESULT_PARITY_EN
   ,
   output logic                      out_parity
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Entry layout (LSB first): data, opcode, [parity].
`ifdef ALU_RESULT_PARITY_EN
   localparam int ENTRY_W = INPUT_WIDTH + OPCODE_WIDTH + 1;
`else
   localparam int ENTRY_W = INPUT_WIDTH + OPCODE_WIDTH;
`endif

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count_q;
   logic               overflow_q;

   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head;

   // Status is derived from registered occupancy only, so in_ready and
   // out_valid never depend combinationally on in_valid or out_ready.
   always_comb begin
      full  = (count_q == CNT_W'(DEPTH));
      empty = (count_q == '0);
      push  = in_valid & ~full;
      pop   = ~empty & out_ready;
   end

   always_comb begin
`ifdef ALU_RESULT_PARITY_EN
      wr_entry = {^in_data, in_opcode, in_data};
`else
      wr_entry = {in_opcode, in_data};
`endif
   end

   // Storage is intentionally not reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         if (in_valid && full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // First-word fall-through head; outputs are forced to zero when empty.
   always_comb begin
      head       = mem[rd_ptr];
      out_data   = '0;
      out_opcode = '0;
      if (!empty) begin
         out_data   = head[INPUT_WIDTH-1:0];
         out_opcode = head[INPUT_WIDTH+OPCODE_WIDTH-1:INPUT_WIDTH];
      end
   end

`ifdef ALU_RESULT_PARITY_EN
   always_comb begin
      out_parity = 1'b0;
      if (!empty) begin
         out_parity = head[ENTRY_W-1];
      end
   end
`endif

   always_comb begin
      in_ready  = ~full;
      out_valid = ~empty;
      out_zero  = ~empty & (head[INPUT_WIDTH-1:0] == '0);
      count     = count_q;
      overflow  = overflow_q;
   end

endmodule
